// File: rtl/bus_pkg.sv
// bus_pkg: definitions shared by bus_valid (initiator) and bus_valid_sink (checker).
//   - bus_state_e : checker FSM state encoding (2-bit)
//   - BUS_DATA_W  : default payload width
//   - LFSR_SEED / LFSR_TAPS and lfsr_fb() : pseudo-random ready generator
package bus_pkg;

    localparam int unsigned BUS_DATA_W = 8;

    typedef enum logic [1:0] {
        S_SYNC       = 2'd0,
        S_SYNC_STALL = 2'd1,
        S_RUN        = 2'd2,
        S_STALL      = 2'd3
    } bus_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 map to register bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_fb(input logic [15:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/bus_ready_gen.sv
// bus_ready_gen: registered ready generator for bus_valid_sink.
// Default build: free-running phase counter 0..READY_PERIOD-1, ready high
// during phases 0..READY_HIGH-1. With BUS_VALID_SINK_LFSR_EN defined, ready
// follows bit 0 of a 16-bit Fibonacci LFSR instead and the period parameters
// are ignored.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset
//   ready - registered ready, 0 in reset
module bus_ready_gen
    import bus_pkg::*;
#(
    parameter int unsigned READY_PERIOD = 4,
    parameter int unsigned READY_HIGH   = 3
) (
    input  logic clk,
    input  logic rst,
    output logic ready
);

`ifdef BUS_VALID_SINK_LFSR_EN

    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr  <= LFSR_SEED;
            ready <= 1'b0;
        end else begin
            lfsr  <= {lfsr[14:0], lfsr_fb(lfsr)};
            ready <= lfsr[0];
        end
    end

`else

    localparam int unsigned PH_W = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;

    logic [PH_W-1:0] phase;

    // ready is computed from the current phase, so the first high ready
    // appears one cycle after reset release (phase 0 is registered then).
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            ready <= 1'b0;
        end else begin
            ready <= (32'(phase) < READY_HIGH);
            if (32'(phase) == READY_PERIOD - 1)
                phase <= '0;
            else
                phase <= phase + 1'b1;
        end
    end

`endif

endmodule

// File: rtl/bus_valid_sink.sv
// bus_valid_sink: responder/checker end of the bus_valid valid/ready stream.
// Accepts beats when valid_i && ready_o, checks the payload increments by one
// (mod 2^DATA_W), flags handshake-rule violations during stalls, and keeps
// saturating beat and sequence-error counters.
// Optional: BUS_VALID_SINK_LFSR_EN selects pseudo-random backpressure.
// Ports:
//   clk           - clock (video_clk)
//   rst           - synchronous active-high reset
//   valid_i       - beat valid from initiator
//   data_i        - beat payload
//   ready_o       - registered ready to initiator
//   beat_cnt_o    - accepted beats, saturating
//   seq_err_cnt_o - sequence mismatches, saturating
//   seq_err_o     - one-cycle pulse after a mismatching accepted beat
//   proto_err_o   - sticky protocol-violation flag
//   last_data_o   - payload of most recent accepted beat
module bus_valid_sink
    import bus_pkg::*;
#(
    parameter int unsigned DATA_W       = BUS_DATA_W,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned READY_PERIOD = 4,
    parameter int unsigned READY_HIGH   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic [CNT_W-1:0]  beat_cnt_o,
    output logic [CNT_W-1:0]  seq_err_cnt_o,
    output logic              seq_err_o,
    output logic              proto_err_o,
    output logic [DATA_W-1:0] last_data_o
);

    bus_state_e        state, state_n;
    logic [DATA_W-1:0] expected, expected_n;
    logic [DATA_W-1:0] latched, latched_n;
    logic              accept;
    logic              check;
    logic              proto_set;

    bus_ready_gen #(
        .READY_PERIOD (READY_PERIOD),
        .READY_HIGH   (READY_HIGH)
    ) u_ready_gen (
        .clk   (clk),
        .rst   (rst),
        .ready (ready_o)
    );

    assign accept = valid_i && ready_o;

    always_comb begin
        state_n    = state;
        expected_n = expected;
        latched_n  = latched;
        check      = 1'b0;
        proto_set  = 1'b0;

        unique case (state)
            S_SYNC: begin
                if (accept) begin
                    expected_n = data_i + DATA_W'(1);
                    state_n    = S_RUN;
                end else if (valid_i) begin
                    latched_n  = data_i;
                    state_n    = S_SYNC_STALL;
                end
            end

            S_SYNC_STALL: begin
                if (!valid_i) begin
                    proto_set = 1'b1;
                    state_n   = S_SYNC;
                end else begin
                    proto_set = (data_i != latched);
                    if (ready_o) begin
                        expected_n = data_i + DATA_W'(1);
                        state_n    = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (accept) begin
                    check      = 1'b1;
                    expected_n = data_i + DATA_W'(1);
                end else if (valid_i) begin
                    latched_n  = data_i;
                    state_n    = S_STALL;
                end
            end

            S_STALL: begin
                if (!valid_i) begin
                    proto_set = 1'b1;
                    state_n   = S_RUN;
                end else begin
                    proto_set = (data_i != latched);
                    if (ready_o) begin
                        check      = 1'b1;
                        expected_n = data_i + DATA_W'(1);
                        state_n    = S_RUN;
                    end
                end
            end

            default: state_n = S_SYNC;
        endcase
    end

    // Reset takes priority, so a beat coinciding with rst is dropped entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_SYNC;
            expected      <= '0;
            latched       <= '0;
            beat_cnt_o    <= '0;
            seq_err_cnt_o <= '0;
            seq_err_o     <= 1'b0;
            proto_err_o   <= 1'b0;
            last_data_o   <= '0;
        end else begin
            state       <= state_n;
            expected    <= expected_n;
            latched     <= latched_n;
            seq_err_o   <= check && (data_i != expected);
            proto_err_o <= proto_err_o | proto_set;

            if (accept) begin
                last_data_o <= data_i;
                if (beat_cnt_o != '1)
                    beat_cnt_o <= beat_cnt_o + 1'b1;
            end

            if (check && (data_i != expected) && (seq_err_cnt_o != '1))
                seq_err_cnt_o <= seq_err_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_valid_sink.sv
// tb_bus_valid_sink: directed self-checking bench for bus_valid_sink.
// Three instances share clk/rst/valid/data: defaults, READY_HIGH=0 (never
// ready) and CNT_W=4 (counter saturation). Expected values are hand-derived.
module tb_bus_valid_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [7:0]  data = 8'h00;

    logic        ready_o, seq_err_o, proto_err_o;
    logic [15:0] beat_cnt_o, seq_err_cnt_o;
    logic [7:0]  last_data_o;

    logic        nr_ready, nr_seq_err, nr_proto_err;
    logic [15:0] nr_beat_cnt, nr_seq_err_cnt;
    logic [7:0]  nr_last_data;

    logic        sat_ready, sat_seq_err, sat_proto_err;
    logic [3:0]  sat_beat_cnt, sat_seq_err_cnt;
    logic [7:0]  sat_last_data;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned seq_pulses = 0;
    logic [7:0]  pulse_data = 8'h00;

    always #5 clk = ~clk;

    bus_valid_sink dut (
        .clk(clk), .rst(rst), .valid_i(valid), .data_i(data),
        .ready_o(ready_o), .beat_cnt_o(beat_cnt_o), .seq_err_cnt_o(seq_err_cnt_o),
        .seq_err_o(seq_err_o), .proto_err_o(proto_err_o), .last_data_o(last_data_o)
    );

    bus_valid_sink #(.READY_HIGH(0)) dut_nr (
        .clk(clk), .rst(rst), .valid_i(valid), .data_i(data),
        .ready_o(nr_ready), .beat_cnt_o(nr_beat_cnt), .seq_err_cnt_o(nr_seq_err_cnt),
        .seq_err_o(nr_seq_err), .proto_err_o(nr_proto_err), .last_data_o(nr_last_data)
    );

    bus_valid_sink #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .valid_i(valid), .data_i(data),
        .ready_o(sat_ready), .beat_cnt_o(sat_beat_cnt), .seq_err_cnt_o(sat_seq_err_cnt),
        .seq_err_o(sat_seq_err), .proto_err_o(sat_proto_err), .last_data_o(sat_last_data)
    );

    // seq_err_o pulse monitor; last_data_o is the flagged beat in that cycle.
    always @(negedge clk) begin
        if (seq_err_o) begin
            seq_pulses <= seq_pulses + 1;
            pulse_data <= last_data_o;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end at posedge+1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Initiator that honours ready: holds valid/data until an accepting edge.
    task automatic send_beat(input logic [7:0] d);
        bit done;
        done = 1'b0;
        valid = 1'b1;
        data = d;
        for (int n = 0; n < 20 && !done; n++) begin
            if (ready_o) done = 1'b1;
            tick();
        end
        valid = 1'b0;
        if (!done) check_eq("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_ready_low();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 10 && !done; n++) begin
            if (!ready_o) done = 1'b1;
            else tick();
        end
        if (!done) check_eq("ready_low_timeout", 32'd0, 32'd1);
    endtask

    int unsigned p0;

    initial begin
        // Reset held 50 cycles, outputs all zero.
        repeat (50) tick();
        check_eq("rst_ready", {31'd0, ready_o}, 32'd0);
        check_eq("rst_beat", {16'd0, beat_cnt_o}, 32'd0);
        check_eq("rst_seqcnt", {16'd0, seq_err_cnt_o}, 32'd0);
        check_eq("rst_seqerr", {31'd0, seq_err_o}, 32'd0);
        check_eq("rst_proto", {31'd0, proto_err_o}, 32'd0);
        check_eq("rst_last", {24'd0, last_data_o}, 32'd0);

        // Ready pattern 1,1,1,0 from the first cycle after release.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq($sformatf("ready_pat%0d", i), {31'd0, ready_o}, ((i % 4) < 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("nr_ready%0d", i), {31'd0, nr_ready}, 32'd0);
        end
        check_eq("idle_beat", {16'd0, beat_cnt_o}, 32'd0);
        check_eq("idle_seqcnt", {16'd0, seq_err_cnt_o}, 32'd0);

        // 0x00..0x09 in order.
        for (int i = 0; i < 10; i++) send_beat(8'(i));
        check_eq("seq10_beat", {16'd0, beat_cnt_o}, 32'd10);
        check_eq("seq10_seqcnt", {16'd0, seq_err_cnt_o}, 32'd0);
        check_eq("seq10_last", {24'd0, last_data_o}, 32'h09);
        check_eq("seq10_proto", {31'd0, proto_err_o}, 32'd0);
        check_eq("nr_beat", {16'd0, nr_beat_cnt}, 32'd0);

        // Wrap 0xFE..0x01 is a valid sequence.
        do_reset();
        p0 = seq_pulses;
        send_beat(8'hFE);
        send_beat(8'hFF);
        send_beat(8'h00);
        send_beat(8'h01);
        tick();
        check_eq("wrap_beat", {16'd0, beat_cnt_o}, 32'd4);
        check_eq("wrap_seqcnt", {16'd0, seq_err_cnt_o}, 32'd0);
        check_eq("wrap_pulses", seq_pulses - p0, 32'd0);
        check_eq("wrap_last", {24'd0, last_data_o}, 32'h01);

        // Gap 06->08: one error on 0x08, resync so 0x09 is fine.
        do_reset();
        p0 = seq_pulses;
        send_beat(8'h05);
        send_beat(8'h06);
        send_beat(8'h08);
        send_beat(8'h09);
        tick();
        check_eq("gap_seqcnt", {16'd0, seq_err_cnt_o}, 32'd1);
        check_eq("gap_pulses", seq_pulses - p0, 32'd1);
        check_eq("gap_pulse_data", {24'd0, pulse_data}, 32'h08);
        check_eq("gap_proto", {31'd0, proto_err_o}, 32'd0);

        // Saturation: 20 beats; CNT_W=4 instance stops at 15.
        do_reset();
        for (int i = 0; i < 20; i++) send_beat(8'(8'h40 + i));
        check_eq("sat20_beat", {16'd0, beat_cnt_o}, 32'd20);
        check_eq("sat4_beat", {28'd0, sat_beat_cnt}, 32'd15);
        check_eq("sat4_seqcnt", {28'd0, sat_seq_err_cnt}, 32'd0);
        check_eq("nr_beat_held", {16'd0, nr_beat_cnt}, 32'd0);

        // Data change during stall -> sticky proto_err.
        do_reset();
        wait_ready_low();
        valid = 1'b1;
        data = 8'h33;
        tick();
        check_eq("stall_pre_proto", {31'd0, proto_err_o}, 32'd0);
        data = 8'h34;
        tick();
        valid = 1'b0;
        check_eq("proto_set", {31'd0, proto_err_o}, 32'd1);
        repeat (5) tick();
        send_beat(8'h35);
        send_beat(8'h36);
        check_eq("proto_sticky", {31'd0, proto_err_o}, 32'd1);

        // Reset during a stall clears everything; no beat counted.
        wait_ready_low();
        valid = 1'b1;
        data = 8'h50;
        tick();
        rst = 1'b1;
        tick();
        valid = 1'b0;
        check_eq("midrst_ready", {31'd0, ready_o}, 32'd0);
        check_eq("midrst_beat", {16'd0, beat_cnt_o}, 32'd0);
        check_eq("midrst_seqcnt", {16'd0, seq_err_cnt_o}, 32'd0);
        check_eq("midrst_seqerr", {31'd0, seq_err_o}, 32'd0);
        check_eq("midrst_proto", {31'd0, proto_err_o}, 32'd0);
        check_eq("midrst_last", {24'd0, last_data_o}, 32'd0);
        rst = 1'b0;
        // Back in S_SYNC: first beat 0x77 is reference only.
        p0 = seq_pulses;
        send_beat(8'h77);
        send_beat(8'h78);
        tick();
        check_eq("post_rst_beat", {16'd0, beat_cnt_o}, 32'd2);
        check_eq("post_rst_seqcnt", {16'd0, seq_err_cnt_o}, 32'd0);
        check_eq("post_rst_pulses", seq_pulses - p0, 32'd0);
        check_eq("post_rst_last", {24'd0, last_data_o}, 32'h78);
        check_eq("post_rst_proto", {31'd0, proto_err_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
